// File: rtl/kmac_right_encode_if.sv
// rtl/kmac_right_encode_if.sv - byte stream interface carrying the right_encode output
interface kmac_right_encode_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;

  modport master (
    output byte_out,
    output byte_valid,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    input  byte_last,
    output byte_ready
  );
endinterface

// File: rtl/kmac_right_encode.sv
// rtl/kmac_right_encode.sv - right_encode(x) byte serialiser: x bytes MSB first, then n
module kmac_right_encode #(
  parameter int VAL_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output logic [3:0]       enc_len,
  output logic             busy,
  output logic             done,
  kmac_right_encode_if.master bs
);

  localparam int NB = VAL_W >> 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_X = 2'd1,
    EMIT_N = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [VAL_W-1:0] x_q;
  logic [3:0]       n_q;
  logic [2:0]       idx;
  logic [3:0]       n_calc;

  // Select byte i (0 = least significant) of x
  function automatic logic [7:0] byte_of(input logic [VAL_W-1:0] x, input logic [2:0] i);
    return 8'(x >> {i, 3'b000});
  endfunction

  // Leading-zero-byte scan: n is one past the highest non-zero byte, minimum 1
  always_comb begin
    n_calc = 4'd1;
    for (int i = 0; i < NB; i++) begin
      if (value[i*8 +: 8] != 8'd0) begin
        n_calc = 4'(i + 1);
      end
    end
  end

  // Control FSM; all stream outputs are registered and loaded one cycle ahead
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      x_q           <= '0;
      n_q           <= 4'd0;
      idx           <= 3'd0;
      enc_len       <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bs.byte_out   <= 8'd0;
      bs.byte_valid <= 1'b0;
      bs.byte_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q           <= value;
            n_q           <= n_calc;
            enc_len       <= n_calc + 4'd1;
            idx           <= 3'(n_calc - 4'd1);
            bs.byte_out   <= byte_of(value, 3'(n_calc - 4'd1));
            bs.byte_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= EMIT_X;
          end
        end
        EMIT_X: begin
          if (bs.byte_valid && bs.byte_ready) begin
            if (idx == 3'd0) begin
              bs.byte_out  <= {4'd0, n_q};
              bs.byte_last <= 1'b1;
              state        <= EMIT_N;
            end else begin
              idx         <= idx - 3'd1;
              bs.byte_out <= byte_of(x_q, idx - 3'd1);
            end
          end
        end
        EMIT_N: begin
          if (bs.byte_valid && bs.byte_ready) begin
            bs.byte_out   <= 8'd0;
            bs.byte_valid <= 1'b0;
            bs.byte_last  <= 1'b0;
            done          <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kmac_right_encode.sv
// tb/tb_kmac_right_encode.sv - directed scoreboard bench for kmac_right_encode
module tb_kmac_right_encode;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] value;
  logic [3:0]  enc_len;
  logic        busy;
  logic        done;

  kmac_right_encode_if bus ();

  kmac_right_encode #(.VAL_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .value   (value),
    .enc_len (enc_len),
    .busy    (busy),
    .done    (done),
    .bs      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_out;
  logic       prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference right_encode: shift until the value fits one byte to find n
  task automatic push_enc(input logic [31:0] v, output int n);
    logic [31:0] tmp;
    tmp = v;
    n = 1;
    while (tmp > 32'd255) begin
      tmp = tmp >> 8;
      n++;
    end
    for (int i = n - 1; i >= 0; i--) exp_q.push_back('{8'(v >> (8 * i)), 1'b0});
    exp_q.push_back('{8'(n), 1'b1});
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < max_cyc);
    checks++;
    assert (done === 1'b1) else begin
      errors++;
      $error("FAIL done_timeout observed %0d cycles expected done pulse", cyc);
    end
  endtask

  // Stream monitor: scoreboard pops, stall stability, zero byte when idle
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid", {31'd0, bus.byte_valid}, 32'd1);
        chk("stall_out", {24'd0, bus.byte_out}, {24'd0, prev_out});
        chk("stall_last", {31'd0, bus.byte_last}, {31'd0, prev_last});
      end
      if (!bus.byte_valid) chk("idle_out_zero", {24'd0, bus.byte_out}, 32'd0);
      if (bus.byte_valid && bus.byte_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_byte observed %0h expected none", bus.byte_out);
        end
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("byte", {24'd0, bus.byte_out}, {24'd0, e.b});
          chk("byte_last", {31'd0, bus.byte_last}, {31'd0, e.last});
        end
      end
      prev_stall = bus.byte_valid && !bus.byte_ready;
      prev_out   = bus.byte_out;
      prev_last  = bus.byte_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int k;
    int hs;
    int dc;
    logic seen;

    rst_n = 1'b0;
    start = 1'b0;
    value = 32'd0;
    bus.byte_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, bus.byte_valid}, 32'd0);
    chk("rst_last", {31'd0, bus.byte_last}, 32'd0);
    chk("rst_out", {24'd0, bus.byte_out}, 32'd0);
    chk("rst_enc_len", {28'd0, enc_len}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // value 0 -> 00 01, done at t+3
    @(posedge clk); #1;
    value = 32'd0; start = 1'b1; bus.byte_ready = 1'b1;
    push_enc(32'd0, n);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("zero_first_valid", {31'd0, bus.byte_valid}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd1);
    chk("zero_enc_len", {28'd0, enc_len}, 32'(n + 1));
    wait_done(20, cyc);
    chk("zero_done_cycle", cyc, 32'(n + 1));
    @(negedge clk);
    chk("zero_done_pulse", {31'd0, done}, 32'd0);
    chk("zero_idle_busy", {31'd0, busy}, 32'd0);
    chk("zero_q_empty", exp_q.size(), 32'd0);

    // value 0x100 -> 01 00 02
    @(posedge clk); #1 value = 32'h100; start = 1'b1;
    push_enc(32'h100, n);
    @(posedge clk); #1 start = 1'b0; value = 32'hFFFF_FFFF;
    wait_done(20, cyc);
    chk("x100_done_cycle", cyc, 32'(n + 2));
    chk("x100_enc_len", {28'd0, enc_len}, 32'd3);
    chk("x100_q_empty", exp_q.size(), 32'd0);

    // 0xDEADBEEF with ready pattern 1,0,0 repeating
    @(posedge clk); #1 value = 32'hDEAD_BEEF; start = 1'b1; bus.byte_ready = 1'b1;
    push_enc(32'hDEAD_BEEF, n);
    @(posedge clk); #1 start = 1'b0; value = 32'd7;
    k = 1; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1 bus.byte_ready = (k % 3 == 0);
        k++;
      end
    end
    chk("dbf_done_cycle", cyc, 32'd14);
    chk("dbf_enc_len", {28'd0, enc_len}, 32'd5);
    chk("dbf_q_empty", exp_q.size(), 32'd0);

    // 0xFF with a second start during EMIT_X that must be ignored
    @(posedge clk); #1 value = 32'hFF; start = 1'b1; bus.byte_ready = 1'b0;
    push_enc(32'hFF, n);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; value = 32'h1234;
    @(posedge clk); #1 start = 1'b0; value = 32'd0; bus.byte_ready = 1'b1;
    wait_done(20, cyc);
    repeat (4) @(negedge clk);
    chk("ff_busy_after", {31'd0, busy}, 32'd0);
    chk("ff_enc_len", {28'd0, enc_len}, 32'd2);
    chk("ff_q_empty", exp_q.size(), 32'd0);

    // reset after second byte accepted
    @(posedge clk); #1 value = 32'h1234_5678; start = 1'b1; bus.byte_ready = 1'b1;
    push_enc(32'h1234_5678, n);
    @(posedge clk); #1 start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.byte_valid && bus.byte_ready) hs++;
    end
    dc = done_cnt;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, bus.byte_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out", {24'd0, bus.byte_out}, 32'd0);
    chk("abort_enc_len", {28'd0, enc_len}, 32'd0);
    chk("abort_remaining", exp_q.size(), 32'd3);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);
    chk("abort_idle_valid", {31'd0, bus.byte_valid}, 32'd0);

    // back-to-back: start in DONE ignored, start in next IDLE accepted
    @(posedge clk); #1 value = 32'hAB; start = 1'b1;
    push_enc(32'hAB, n);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 start = 1'b1; value = 32'h5555;
    @(negedge clk);
    chk("b2b_done_cycle", {31'd0, done}, 32'd1);
    @(posedge clk); #1 value = 32'h0102;
    push_enc(32'h0102, n);
    @(posedge clk); #1 start = 1'b0; value = 32'd0;
    wait_done(20, cyc);
    chk("b2b_done_cycle2", cyc, 32'(n + 2));
    chk("b2b_enc_len", {28'd0, enc_len}, 32'd3);
    chk("b2b_q_empty", exp_q.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kmac_right_encode.md
KMAC_RIGHT_ENCODE -- requirements
Module: kmac_right_encode

Interface
REQ-001 SHALL have parameter VAL_W, default 32, bit width of the value to encode; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to encode value; sampled only in IDLE.
REQ-005 SHALL have port value  input  VAL_W  unsigned integer x to encode; sampled in the start cycle.
REQ-006 SHALL have port byte_out  output  8  current encoded byte.
REQ-007 SHALL have port byte_valid  output  1  byte_out holds a valid byte.
REQ-008 SHALL have port byte_ready  input  1  consumer accepts byte_out this cycle.
REQ-009 SHALL have port byte_last  output  1  current byte is the final (length) byte.
REQ-010 SHALL have port enc_len  output  4  total encoded byte count n+1, valid from the cycle after start until the next accepted start.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the final byte is accepted.

Function
REQ-013 SHALL implement NIST SP 800-185 right_encode(x): x_1..x_n || enc8(n).
REQ-014 n SHALL be the minimal number of bytes holding x, with n = 1 when x = 0.
REQ-015 x_1..x_n SHALL be emitted most-significant byte first.
REQ-016 The final byte SHALL be enc8(n), i.e. the value n in 8 bits.
REQ-017 The FSM SHALL have states IDLE, EMIT_X, EMIT_N and DONE.
REQ-018 IDLE with start=1 SHALL latch value, compute n, load byte index n-1 and go to EMIT_X.
REQ-019 In IDLE with start=0 the FSM SHALL hold.
REQ-020 In EMIT_X, byte_valid SHALL be 1 and byte_out SHALL be latched-x byte [index].
REQ-021 On byte_valid && byte_ready in EMIT_X, the index SHALL decrement; after index 0 the FSM SHALL go to EMIT_N.
REQ-022 In EMIT_N, byte_valid=1, byte_last=1 and byte_out=n SHALL hold; on handshake the FSM SHALL go to DONE.
REQ-023 In DONE, done=1 and byte_valid=0 SHALL hold, with an unconditional return to IDLE next cycle.
REQ-024 While byte_valid=1 && byte_ready=0, byte_out, byte_last and byte_valid SHALL stay stable.
REQ-025 byte_valid SHALL never deassert without a handshake.
REQ-026 start SHALL be ignored in EMIT_X, EMIT_N and DONE, with no effect on the latched value or the stream.
REQ-027 Changes to value after the start cycle SHALL have no effect.
REQ-028 Latency: start accepted at cycle t gives the first byte_valid at t+1.
REQ-029 With byte_ready held high, the n+1 bytes SHALL appear on consecutive cycles t+1..t+n+1, with done at t+n+2.
REQ-030 start asserted in the DONE cycle SHALL be ignored; start SHALL be accepted from the following IDLE cycle.
REQ-031 byte_out SHALL be 0 whenever byte_valid=0.
REQ-032 n computation SHALL use a leading-zero-byte scan over VAL_W/8 bytes, with no division.

Reset
REQ-033 While rst_n=0: state IDLE, byte_valid=0, byte_last=0, byte_out=0, enc_len=0, busy=0, done=0, latched value and index 0.
REQ-034 Reset asserted mid-stream SHALL abort immediately and emit no further bytes.
REQ-035 After reset release, the first start SHALL be handled as from power-up.

Verification
REQ-036 value=0, start, ready=1 -> bytes 0x00,0x01; last on 2nd byte; enc_len=2; done at t+3.
REQ-037 value=0x100, ready=1 -> bytes 0x01,0x00,0x02; enc_len=3.
REQ-038 value=0xDEADBEEF, ready toggling 1,0,0,1,... -> bytes 0xDE,0xAD,0xBE,0xEF,0x04; outputs stable during stalls; enc_len=5.
REQ-039 value=0xFF, start re-pulsed with value=0x1234 during EMIT_X -> bytes 0xFF,0x01 only; second start ignored.
REQ-040 value=0x12345678, rst_n pulsed low after 2nd byte accepted -> byte_valid=0 at once, busy=0, no further bytes, no done.
REQ-041 Back-to-back encodes: start in DONE cycle ignored; start in next IDLE cycle produces a correct new stream.
